// File: rtl/common.sv
// rtl/common.sv - shared types for the fetch path and the program loader
//
// if_id_type       : fetch-to-decode pipeline register; pc addresses instruction memory by word
// loader_state_type: program loader session states

package common;

    typedef struct packed {
        logic [4:0]  pc;
        logic [31:0] instruction;
    } if_id_type;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        WRITE,
        DONE
    } loader_state_type;

endpackage

// File: rtl/program_loader_word_packer.sv
// rtl/program_loader_word_packer.sv - packs accepted bytes into a little-endian 32-bit word
//
// clk, reset    : clock, synchronous active-high reset
// clear         : restart packing at lane 0 (new session)
// byte_valid    : a byte is accepted this cycle
// byte_data     : accepted byte
// word          : assembled word, lane 0 in bits [7:0]
// byte_idx      : lane the next accepted byte goes to
// word_complete : the byte accepted this cycle fills lane 3

module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic [1:0]  byte_idx,
    output logic        word_complete
);

    logic [3:0][7:0] lanes_q;
    logic [1:0]      byte_idx_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lanes_q    <= '0;
            byte_idx_q <= 2'd0;
        end else if (byte_valid) begin
            lanes_q[byte_idx_q] <= byte_data;
            // Wraps from 3 back to 0, so the next word starts at lane 0.
            byte_idx_q          <= byte_idx_q + 2'd1;
        end
    end

    assign word          = lanes_q;
    assign byte_idx      = byte_idx_q;
    assign word_complete = byte_valid && (byte_idx_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a count-prefixed byte stream into instruction memory
//
// clk, reset          : clock, synchronous active-high reset
// start               : begin a load session (only honoured when idle)
// rx_data/valid/ready : byte stream handshake
// imem_write_*        : one-cycle word write into instruction memory
// cpu_hold            : keeps the pipeline in reset while a session is active
// load_done           : one-cycle pulse after the last word is written
// load_error          : one-cycle pulse after an out-of-range count byte

module program_loader
    import common::*;
#(
    parameter int IMEM_ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic                       imem_write_enable,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_write_address,
    output logic [31:0]                imem_write_data,
    output logic                       cpu_hold,
    output logic                       load_done,
    output logic                       load_error
);

    localparam int DEPTH = 2 ** IMEM_ADDR_WIDTH;

    loader_state_type state_q, next_state;

    // Count register is one bit wider than the word index so N==DEPTH fits.
    logic [IMEM_ADDR_WIDTH:0]   count_q;
    logic [IMEM_ADDR_WIDTH-1:0] word_idx_q;
    logic                       error_q;

    logic        handshake;
    logic        count_bad;
    logic        count_accept;
    logic        last_word;
    logic        packer_valid;
    logic [31:0] packed_word;
    logic [1:0]  byte_idx;
    logic        word_complete;

    assign handshake    = rx_valid && rx_ready;
    assign count_bad    = (rx_data == 8'd0) || ({24'd0, rx_data} > DEPTH);
    assign count_accept = (state_q == COUNT) && handshake && !count_bad;
    assign packer_valid = (state_q == DATA) && handshake;
    assign last_word    = ({1'b0, word_idx_q} == (count_q - 1'b1));

    word_packer u_word_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (count_accept),
        .byte_valid    (packer_valid),
        .byte_data     (rx_data),
        .word          (packed_word),
        .byte_idx      (byte_idx),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q <= next_state;
            // Registered so the error pulse lands in the first IDLE cycle.
            error_q <= (state_q == COUNT) && handshake && count_bad;
            if (count_accept) begin
                count_q    <= (IMEM_ADDR_WIDTH + 1)'(rx_data);
                word_idx_q <= '0;
            end else if ((state_q == WRITE) && !last_word) begin
                word_idx_q <= word_idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        next_state         = state_q;
        rx_ready           = 1'b0;
        imem_write_enable  = 1'b0;
        imem_write_address = '0;
        imem_write_data    = '0;
        cpu_hold           = 1'b1;
        load_done          = 1'b0;
        load_error         = error_q;
        case (state_q)
            IDLE: begin
                cpu_hold = 1'b0;
                if (start) begin
                    next_state = COUNT;
                end
            end
            COUNT: begin
                rx_ready = 1'b1;
                if (handshake) begin
                    next_state = count_bad ? IDLE : DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (word_complete) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                imem_write_enable  = 1'b1;
                imem_write_address = word_idx_q;
                imem_write_data    = packed_word;
                next_state         = last_word ? DONE : DATA;
            end
            DONE: begin
                load_done  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // byte_idx is exposed by the packer for observability; the FSM only needs word_complete.
    logic unused_byte_idx;
    assign unused_byte_idx = ^byte_idx;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader

module tb_program_loader;

    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_write_enable;
    logic [AW-1:0] imem_write_address;
    logic [31:0]   imem_write_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;

    program_loader #(.IMEM_ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_ready           (rx_ready),
        .imem_write_enable  (imem_write_enable),
        .imem_write_address (imem_write_address),
        .imem_write_data    (imem_write_data),
        .cpu_hold           (cpu_hold),
        .load_done          (load_done),
        .load_error         (load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Observation of DUT activity, sampled just after each rising edge.
    int          cyc = 0;
    int          write_count, done_count, error_count;
    int          last_write_cycle, done_cycle, error_cycle, hold_fall_cycle;
    bit          ready_in_write;
    bit          prev_hold = 1'b0;
    logic [31:0] obs_mem [DEPTH];
    int          obs_addr_q [$];

    // Reference: the byte payload following the count byte, and the image it implies.
    logic [7:0]  pay [$];
    logic [31:0] exp_mem [DEPTH];
    bit          byte_timeout;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (imem_write_enable) begin
            obs_mem[imem_write_address] = imem_write_data;
            obs_addr_q.push_back(int'(imem_write_address));
            write_count++;
            last_write_cycle = cyc;
            if (rx_ready) ready_in_write = 1'b1;
        end
        if (load_done) begin
            done_count++;
            done_cycle = cyc;
        end
        if (load_error) begin
            error_count++;
            error_cycle = cyc;
        end
        if (prev_hold && !cpu_hold) hold_fall_cycle = cyc;
        prev_hold = cpu_hold;
    end

    task automatic clear_monitor();
        write_count      = 0;
        done_count       = 0;
        error_count      = 0;
        last_write_cycle = -100;
        done_cycle       = -100;
        error_cycle      = -100;
        hold_fall_cycle  = -100;
        ready_in_write   = 1'b0;
        obs_addr_q.delete();
        for (int i = 0; i < DEPTH; i++) obs_mem[i] = 32'hxxxx_xxxx;
    endtask

    // Model: word i is bytes 4i..4i+3 of the payload, first byte least significant.
    task automatic build_model(input int n);
        for (int i = 0; i < n; i++)
            exp_mem[i] = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit sampled;
        bit ok;
        if (gaps && ($urandom_range(0, 2) == 0)) repeat ($urandom_range(1, 3)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        ok       = 1'b0;
        for (int t = 0; t < 50; t++) begin
            sampled = rx_ready;
            @(posedge clk);
            if (sampled) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (!ok) byte_timeout = 1'b1;
    endtask

    task automatic load_session(input logic [7:0] nb, input bit gaps, input int mid_start);
        int t;
        clear_monitor();
        byte_timeout = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cpu_hold !== 1'b1) begin
            fails++;
            $display("FAIL hold_rise: cpu_hold=%b required 1", cpu_hold);
        end
        send_byte(nb, gaps);
        for (int i = 0; i < pay.size(); i++) begin
            if (i == mid_start) start = 1'b1;
            send_byte(pay[i], gaps);
            start = 1'b0;
        end
        for (t = 0; t < 300; t++) begin
            if (done_count + error_count > 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (byte_timeout || (done_count + error_count == 0)) begin
            fails++;
            $display("FAIL session_end: timeout=%b done=%0d error=%0d required a completion",
                     byte_timeout, done_count, error_count);
        end
    endtask

    task automatic random_payload(input int n);
        pay.delete();
        for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        clear_monitor();
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, imem_write_enable, cpu_hold, load_done, load_error, imem_write_address, imem_write_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b we=%b hold=%b done=%b err=%b addr=%h data=%h required all 0",
                     rx_ready, imem_write_enable, cpu_hold, load_done, load_error, imem_write_address, imem_write_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_ready, cpu_hold, imem_write_enable} !== 3'b000) begin
            fails++;
            $display("FAIL post_reset_idle: ready=%b hold=%b we=%b required 000", rx_ready, cpu_hold, imem_write_enable);
        end
    endtask

    task automatic test_single_word();
        pay = '{8'h13, 8'h00, 8'h00, 8'h00};
        load_session(8'd1, 1'b0, -1);
        checks++;
        if (write_count !== 1 || obs_addr_q.size() == 0 || obs_addr_q[0] !== 0) begin
            fails++;
            $display("FAIL single_write: writes=%0d required 1 at address 0", write_count);
        end
        checks++;
        if (obs_mem[0] !== 32'h0000_0013) begin
            fails++;
            $display("FAIL single_data: got %h required 00000013", obs_mem[0]);
        end
        checks++;
        if (done_count !== 1 || done_cycle !== last_write_cycle + 1) begin
            fails++;
            $display("FAIL single_done: pulses=%0d at %0d required 1 at %0d", done_count, done_cycle, last_write_cycle + 1);
        end
        checks++;
        if (hold_fall_cycle !== last_write_cycle + 2) begin
            fails++;
            $display("FAIL single_hold_fall: cycle %0d required %0d", hold_fall_cycle, last_write_cycle + 2);
        end
    endtask

    task automatic test_two_words_gaps();
        pay = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h33, 8'h01, 8'h31, 8'h00};
        load_session(8'd2, 1'b1, -1);
        checks++;
        if (write_count !== 2 || obs_mem[0] !== 32'h0010_0093 || obs_mem[1] !== 32'h0031_0133) begin
            fails++;
            $display("FAIL two_words: writes=%0d m0=%h m1=%h required 2, 00100093, 00310133",
                     write_count, obs_mem[0], obs_mem[1]);
        end
        checks++;
        if (ready_in_write !== 1'b0) begin
            fails++;
            $display("FAIL ready_in_write: rx_ready seen %b during a write, required 0", ready_in_write);
        end
    endtask

    task automatic test_bad_counts();
        logic [7:0] bad [3];
        bad[0] = 8'd0;
        bad[1] = 8'd33;
        bad[2] = 8'($urandom_range(34, 255));
        for (int k = 0; k < 3; k++) begin
            pay.delete();
            load_session(bad[k], 1'b0, -1);
            checks++;
            if (error_count !== 1 || write_count !== 0 || done_count !== 0) begin
                fails++;
                $display("FAIL bad_count_%0d: errors=%0d writes=%0d dones=%0d required 1,0,0",
                         bad[k], error_count, write_count, done_count);
            end
            checks++;
            if (hold_fall_cycle !== error_cycle) begin
                fails++;
                $display("FAIL bad_count_hold_%0d: hold fell at %0d required %0d", bad[k], hold_fall_cycle, error_cycle);
            end
        end
    endtask

    task automatic test_full_depth();
        bit bad_data;
        random_payload(DEPTH);
        build_model(DEPTH);
        load_session(8'(DEPTH), 1'b0, -1);
        checks++;
        if (write_count !== DEPTH || obs_addr_q.size() != DEPTH || obs_addr_q[DEPTH-1] !== DEPTH - 1) begin
            fails++;
            $display("FAIL full_depth_writes: writes=%0d required %0d ending at %0d", write_count, DEPTH, DEPTH - 1);
        end
        bad_data = 1'b0;
        for (int i = 0; i < DEPTH; i++) if (obs_mem[i] !== exp_mem[i]) bad_data = 1'b1;
        checks++;
        if (bad_data || done_count !== 1) begin
            fails++;
            $display("FAIL full_depth_data: image differs=%b dones=%0d required 0,1", bad_data, done_count);
        end
    endtask

    task automatic test_random_sessions();
        int  n;
        bit  bad;
        for (int s = 0; s < 5; s++) begin
            n = $urandom_range(1, 12);
            random_payload(n);
            build_model(n);
            load_session(8'(n), bit'($urandom_range(0, 1)), -1);
            bad = (write_count != n) || (obs_addr_q.size() != n);
            for (int i = 0; i < n && !bad; i++)
                if (obs_addr_q[i] != i || obs_mem[i] !== exp_mem[i]) bad = 1'b1;
            checks++;
            if (bad || done_count !== 1) begin
                fails++;
                $display("FAIL random_session_%0d: n=%0d writes=%0d dones=%0d image mismatch=%b",
                         s, n, write_count, done_count, bad);
            end
        end
    endtask

    task automatic test_reset_mid_session();
        clear_monitor();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'd3, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({rx_ready, imem_write_enable, cpu_hold, load_done, load_error, imem_write_address, imem_write_data} !== '0
            || write_count !== 0) begin
            fails++;
            $display("FAIL reset_mid: ready=%b we=%b hold=%b data=%h writes=%0d required all 0",
                     rx_ready, imem_write_enable, cpu_hold, imem_write_data, write_count);
        end
        reset = 1'b0;
        random_payload(1);
        build_model(1);
        load_session(8'd1, 1'b0, -1);
        checks++;
        if (write_count !== 1 || obs_mem[0] !== exp_mem[0]) begin
            fails++;
            $display("FAIL after_reset_load: writes=%0d data=%h required 1, %h", write_count, obs_mem[0], exp_mem[0]);
        end
    endtask

    task automatic test_start_mid_data();
        random_payload(2);
        build_model(2);
        load_session(8'd2, 1'b0, 2);
        checks++;
        if (write_count !== 2 || obs_mem[0] !== exp_mem[0] || obs_mem[1] !== exp_mem[1] || done_count !== 1) begin
            fails++;
            $display("FAIL start_mid_data: writes=%0d m0=%h m1=%h dones=%0d required 2, %h, %h, 1",
                     write_count, obs_mem[0], obs_mem[1], done_count, exp_mem[0], exp_mem[1]);
        end
    endtask

    task automatic test_valid_in_idle();
        bit bad;
        clear_monitor();
        bad = 1'b0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h01;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_ready !== 1'b0 || cpu_hold !== 1'b0) bad = 1'b1;
        end
        rx_valid = 1'b0;
        checks++;
        if (bad || write_count !== 0 || done_count !== 0 || error_count !== 0) begin
            fails++;
            $display("FAIL valid_in_idle: ready/hold raised=%b writes=%0d dones=%0d errors=%0d required 0",
                     bad, write_count, done_count, error_count);
        end
        random_payload(1);
        build_model(1);
        load_session(8'd1, 1'b0, -1);
        checks++;
        if (write_count !== 1 || obs_mem[0] !== exp_mem[0]) begin
            fails++;
            $display("FAIL load_after_idle_valid: writes=%0d data=%h required 1, %h", write_count, obs_mem[0], exp_mem[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words_gaps();
        test_bad_counts();
        test_full_depth();
        test_random_sessions();
        test_reset_mid_session();
        test_start_mid_data();
        test_valid_in_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
